keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Scans a 4x3 matrix keypad, debounces it, and encodes each press into the 4-bit key code the elevator access manager consumes on its `in` bus.
- Codes: 0-9 = 4'b0000-4'b1001, star = 4'b1010, hash = 4'b1011.
- Emits one code plus a single-cycle valid strobe per physical press.
- Sits between the board keypad pins and the manager.

Parameters:
- SCAN_DIV, 16: clock cycles each row is driven before its columns are sampled; must be >= 4.
- DEBOUNCE, 8: consecutive stable samples required to accept a press and to accept a release; must be >= 2.
- CNT_W, 16: width of the dwell and debounce counters; must hold max(SCAN_DIV, DEBOUNCE).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  scanning enabled when high.
- col_n  input  3  keypad columns, active-low, asynchronous to clk. Bit0 = left, bit2 = right.
- row_n  output  4  keypad row drive, active-low, one-hot when scanning. Bit0 = top row.
- key_code  output  4  last accepted key code; held until the next accepted key.
- key_valid  output  1  one-cycle strobe, asserted in the cycle key_code is updated.
- key_held  output  1  high from the accept cycle until the release is debounced.

Behaviour:
- Reset values (asynchronous, while rst = 1):
  - row_n = 4'b1110; key_code = 4'b1111 (no key); key_valid = 0; key_held = 0.
  - State SCAN, row index 0, all counters 0, synchroniser flops all 1.
- col_n passes through a 2-flop synchroniser reset to 3'b111. All decisions below use the synchronised value cs.
- Keypad layout by row (left to right):
  - row0: 1, 2, 3
  - row1: 4, 5, 6
  - row2: 7, 8, 9
  - row3: *, 0, #
- States: SCAN, DEB_PRESS, ACCEPT, WAIT_REL.
- SCAN:
  - Drives row r low. The dwell counter counts 0 .. SCAN_DIV-1; cs is sampled only on the cycle dwell = SCAN_DIV-1.
  - Exactly one bit of cs low: capture r and the column, go to DEB_PRESS with the debounce counter at 1.
  - cs = 3'b111, or two or more bits low (multi-key ghosting): advance r = (r+1) mod 4 (3 wraps to 0), reset dwell to 0.
- DEB_PRESS:
  - Row r stays driven.
  - Each cycle cs equals the captured pattern: increment the counter. On reaching DEBOUNCE, go to ACCEPT.
  - Any mismatch: return to SCAN on the same row with dwell 0; no output change.
- ACCEPT (exactly one cycle):
  - key_code <= encoded key; key_valid = 1; key_held <= 1.
  - Go to WAIT_REL with the counter at 0.
- WAIT_REL:
  - Row r stays driven.
  - Each cycle cs = 3'b111: increment the counter. Any low bit: reset the counter to 0.
  - On reaching DEBOUNCE: key_held <= 0, advance r, go to SCAN.
  - Holding a key for any duration produces exactly one key_valid.
- enable:
  - enable = 0 in any state forces row_n = 4'b1111 and the next state SCAN with row 0 and counters 0.
  - Key_held clears. key_code keeps its value. No key_valid is produced; a press in DEB_PRESS is aborted.
  - Scanning resumes with row 0 on the first cycle enable = 1.
- rst mid-operation: immediate return to the reset values; a pending press is discarded.
- Latency:
  - First key_valid comes DEBOUNCE+1 cycles after the SCAN sample cycle that saw the key.
  - Column-to-sample path adds 2 synchroniser cycles.
- key_valid is never high on two consecutive cycles.

Test Plan:
1. Reset, then hold col_n = 3'b101 only while row_n = 4'b1101 (key 5) for 200 cycles, then release -> key_code = 4'b0101, exactly one key_valid pulse, key_held high until DEBOUNCE cycles after release, row_n resumes at 4'b1011.
2. Press '*' (row3, col0) for only DEBOUNCE-3 cycles after detection, then release -> no key_valid, key_code remains 4'b1111.
3. Press 2 and 3 simultaneously (row0, col_n = 3'b001) -> no key_valid; rows continue cycling 1110, 1101, 1011, 0111, 1110.
4. Sequence *, 0, 0, 1 with debounced releases -> four key_valid pulses with key_code 1010, 0000, 0000, 0001 in order.
5. Assert rst while in DEB_PRESS for key '#' -> all outputs return to reset values immediately, no key_valid.
6. Drop enable while a key is held in WAIT_REL -> row_n = 4'b1111, key_held = 0, key_code unchanged; re-enable with no key pressed -> scanning resumes at 4'b1110, no spurious key_valid.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: rotates an active-low row drive, debounces the
// synchronised columns and emits one encoded key code plus a strobe per press.
module keypad_scanner #(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 8,
  parameter int CNT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] col_n,
  output logic [3:0] row_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, ACCEPT, WAIT_REL} state_t;

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE - 1);

  state_t           state_q, state_d;
  logic [2:0]       sync1_q, cs_q;
  logic [1:0]       row_q, row_d;
  logic [CNT_W-1:0] dwell_q, dwell_d, deb_q, deb_d;
  logic [2:0]       cap_q, cap_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d, held_q, held_d;
  logic             one_low;

  function automatic logic [3:0] encode(input logic [1:0] r, input logic [2:0] c_n);
    logic [3:0] col;
    case (c_n)
      3'b110:  col = 4'd0;
      3'b101:  col = 4'd1;
      default: col = 4'd2;
    endcase
    // Bottom row is *, 0, # rather than continuing the digit sequence.
    if (r == 2'd3)
      encode = (col == 4'd0) ? 4'd10 : (col == 4'd1) ? 4'd0 : 4'd11;
    else
      encode = {2'b00, r} * 4'd3 + col + 4'd1;
  endfunction

  assign one_low = (cs_q == 3'b110) || (cs_q == 3'b101) || (cs_q == 3'b011);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    deb_d   = deb_q;
    cap_d   = cap_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          // Ghosted multi-key patterns are treated like no key.
          if (one_low) begin
            cap_d   = cs_q;
            deb_d   = CNT_W'(1);
            state_d = DEB_PRESS;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      DEB_PRESS: begin
        if (cs_q == cap_q) begin
          if (deb_q == DEB_LAST) begin
            deb_d   = '0;
            state_d = ACCEPT;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          dwell_d = '0;
          deb_d   = '0;
          state_d = SCAN;
        end
      end
      ACCEPT: begin
        code_d  = encode(row_q, cap_q);
        valid_d = 1'b1;
        held_d  = 1'b1;
        deb_d   = '0;
        state_d = WAIT_REL;
      end
      default: begin
        if (cs_q == 3'b111) begin
          if (deb_q == DEB_LAST) begin
            held_d  = 1'b0;
            row_d   = row_q + 2'd1;
            dwell_d = '0;
            deb_d   = '0;
            state_d = SCAN;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          deb_d = '0;
        end
      end
    endcase
    if (!enable) begin
      state_d = SCAN;
      row_d   = 2'd0;
      dwell_d = '0;
      deb_d   = '0;
      held_d  = 1'b0;
      valid_d = 1'b0;
      code_d  = code_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCAN;
      sync1_q <= 3'b111;
      cs_q    <= 3'b111;
      row_q   <= 2'd0;
      dwell_q <= '0;
      deb_q   <= '0;
      cap_q   <= 3'b111;
      code_q  <= 4'b1111;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= col_n;
      cs_q    <= sync1_q;
      row_q   <= row_d;
      dwell_q <= dwell_d;
      deb_q   <= deb_d;
      cap_q   <= cap_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign row_n     = enable ? ~(4'b0001 << row_q) : 4'b1111;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives the columns, a
// scoreboard queue holds expected key codes, and a monitor pops on key_valid.
module tb_keypad_scanner;
  localparam int SCAN_DIV = 16;
  localparam int DEBOUNCE = 8;
  localparam int CNT_W    = 16;

  logic       clk = 1'b0;
  logic       rst, enable;
  logic [2:0] col_n;
  logic [3:0] row_n, key_code;
  logic       key_valid, key_held;
  logic [11:0] pressed;

  int nvec = 0;
  int nerr = 0;
  logic [3:0] exp_q[$];
  int codes[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
  logic [3:0] seq[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .col_n(col_n),
    .row_n(row_n), .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  // Key k sits at row k/3, column k%3; a pressed key shorts its column to a driven row.
  always_comb begin
    col_n = 3'b111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (pressed[r*3+c] && !row_n[r]) col_n[c] = 1'b0;
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_row(input logic [3:0] target);
    int budget;
    budget = 0;
    while (row_n == target && budget < 200) begin cyc(1); budget++; end
    while (row_n != target && budget < 200) begin cyc(1); budget++; end
    if (budget >= 200) begin
      nvec++; nerr++;
      $display("FAIL wait_row: timeout waiting for row_n %b", target);
    end
  endtask

  task automatic press(input int k, input int hold, input int gap, input bit expect_it);
    if (expect_it) exp_q.push_back(4'(codes[k]));
    pressed = '0;
    pressed[k] = 1'b1;
    cyc(hold);
    pressed = '0;
    cyc(gap);
  endtask

  initial begin : monitor
    logic pv;
    logic [3:0] e;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) pv = 1'b0;
      else begin
        if (key_valid) begin
          nvec++;
          if (pv) begin
            nerr++;
            $display("FAIL valid_twice: key_valid high on consecutive cycles at %0t", $time);
          end
          if (exp_q.size() == 0) begin
            nvec++; nerr++;
            $display("FAIL unexpected_valid: code %b, none expected at %0t", key_code, $time);
          end else begin
            e = exp_q.pop_front();
            check("key_code", key_code, e);
            check("held_at_valid", {3'b000, key_held}, 4'd1);
          end
        end
        pv = key_valid;
      end
    end
  end

  initial begin : stim
    int budget, changes, idx, kind, k, r, c, c2;
    logic [3:0] prev;
    rst = 1'b1; enable = 1'b1; pressed = '0;
    #1;
    check("rst_row_n", row_n, 4'b1110);
    check("rst_key_code", key_code, 4'b1111);
    check("rst_key_valid", {3'b000, key_valid}, 4'd0);
    check("rst_key_held", {3'b000, key_held}, 4'd0);
    cyc(3);
    rst = 1'b0;

    // Short '*' press straddling the row-3 sample: never long enough to accept.
    wait_row(4'b0111);
    cyc(SCAN_DIV - 4);
    press(9, DEBOUNCE - 3, 50, 1'b0);
    check("short_code", key_code, 4'b1111);

    // Key 5 held, then released: held drops DEBOUNCE cycles after release.
    press(4, 200, 0, 1'b1);
    cyc(DEBOUNCE + 1);
    check("held_before_rel", {3'b000, key_held}, 4'd1);
    cyc(1);
    check("held_after_rel", {3'b000, key_held}, 4'd0);
    check("row_after_rel", row_n, 4'b1011);
    check("code_5", key_code, 4'b0101);

    // Ghosted 2+3 on row 0: rows must keep rotating.
    pressed = '0; pressed[1] = 1'b1; pressed[2] = 1'b1;
    prev = row_n; changes = 0;
    for (int i = 0; i < 6 * SCAN_DIV; i++) begin
      cyc(1);
      if (row_n != prev) begin
        idx = 0;
        for (int j = 0; j < 4; j++) if (seq[j] == prev) idx = j;
        check("row_order", row_n, seq[(idx + 1) % 4]);
        changes++;
        prev = row_n;
      end
    end
    nvec++;
    if (changes < 4) begin
      nerr++;
      $display("FAIL row_cycling: got %0d row changes expected at least 4", changes);
    end
    pressed = '0;
    cyc(30);

    // Sequence *, 0, 0, 1.
    press(9, 120, 30, 1'b1);
    press(10, 120, 30, 1'b1);
    press(10, 120, 30, 1'b1);
    press(0, 120, 30, 1'b1);

    // Reset while '#' is being debounced.
    wait_row(4'b0111);
    pressed = '0; pressed[11] = 1'b1;
    cyc(SCAN_DIV + 2);
    rst = 1'b1;
    #1;
    check("mid_rst_row_n", row_n, 4'b1110);
    check("mid_rst_key_code", key_code, 4'b1111);
    check("mid_rst_key_valid", {3'b000, key_valid}, 4'd0);
    check("mid_rst_key_held", {3'b000, key_held}, 4'd0);
    cyc(2);
    pressed = '0;
    rst = 1'b0;
    cyc(40);

    // Drop enable while key 9 is held.
    exp_q.push_back(4'd9);
    pressed = '0; pressed[8] = 1'b1;
    budget = 0;
    while (!key_held && budget < 300) begin cyc(1); budget++; end
    if (budget >= 300) begin
      nvec++; nerr++;
      $display("FAIL held_wait: key_held never rose for key 9");
    end
    cyc(10);
    enable = 1'b0;
    #1;
    check("dis_row_n", row_n, 4'b1111);
    cyc(1);
    check("dis_key_held", {3'b000, key_held}, 4'd0);
    check("dis_key_code", key_code, 4'b1001);
    pressed = '0;
    cyc(20);
    enable = 1'b1;
    #1;
    check("reen_row_n", row_n, 4'b1110);
    cyc(200);

    // Randomised presses: long singles, too-short taps, same-row ghost pairs.
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 3);
      k = $urandom_range(0, 11);
      if (kind <= 1) press(k, $urandom_range(80, 200), 0, 1'b1);
      else if (kind == 2) press(k, $urandom_range(1, DEBOUNCE - 1), 0, 1'b0);
      else begin
        r = $urandom_range(0, 3);
        c = $urandom_range(0, 2);
        c2 = (c + $urandom_range(1, 2)) % 3;
        pressed = '0; pressed[r*3+c] = 1'b1; pressed[r*3+c2] = 1'b1;
        cyc($urandom_range(80, 200));
        pressed = '0;
      end
      cyc($urandom_range(DEBOUNCE + 6, 40));
    end
    cyc(100);
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL missing_valid: %0d expected codes never seen, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
